// File: rtl/serial_add_arbiter_if.sv
`default_nettype none
// ============================================================================
// serial_add_arbiter_if : two-requester add request/result bundle
// Revision: 1.0
// ============================================================================
interface serial_add_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             cin0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             cin1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output req0, a0, b0, cin0, req1, a1, b1, cin1,
    input  gnt0, gnt1, busy, done, done_id, sum, cout
  );

  modport slave (
    input  req0, a0, b0, cin0, req1, a1, b1, cin1,
    output gnt0, gnt1, busy, done, done_id, sum, cout
  );
endinterface
`default_nettype wire

// File: rtl/serial_add_arbiter.sv
`default_nettype none
// ============================================================================
// serial_add_arbiter : round-robin shared 2-bit adder slice, digit-serial
// Revision: 1.0
// ============================================================================
module serial_add_arbiter #(
  parameter int WIDTH = 8
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  serial_add_arbiter_if.slave bus
);
  localparam int c_digits = WIDTH / 2;
  localparam int c_idx_w  = (c_digits > 1) ? $clog2(c_digits) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_digits - 1);
  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_add  = 1'b1;

  logic [0:0]         r_state;
  logic [c_idx_w-1:0] r_idx;
  logic               r_carry;
  logic               r_last;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_gnt0;
  logic               r_gnt1;
  logic               r_done;
  logic               r_done_id;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;

  logic               w_any_req;
  logic               w_win;
  logic [c_idx_w:0]   w_bit_pos;
  logic [2:0]         w_slice;

  assign w_any_req = bus.req0 | bus.req1;
  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign w_win     = bus.req1 & (~bus.req0 | ~r_last);
  assign w_bit_pos = {r_idx, 1'b0};
  assign w_slice   = {1'b0, r_a[w_bit_pos +: 2]} + {1'b0, r_b[w_bit_pos +: 2]} + {2'b00, r_carry};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= c_st_idle;
      r_idx     <= '0;
      r_carry   <= 1'b0;
      r_last    <= 1'b1;
      r_a       <= '0;
      r_b       <= '0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      r_done <= 1'b0;
      if (r_state == c_st_idle) begin
        if (w_any_req) begin
          r_a     <= w_win ? bus.a1 : bus.a0;
          r_b     <= w_win ? bus.b1 : bus.b0;
          r_carry <= w_win ? bus.cin1 : bus.cin0;
          r_idx   <= '0;
          r_last  <= w_win;
          r_gnt0  <= ~w_win;
          r_gnt1  <= w_win;
          r_state <= c_st_add;
        end
      end else begin
        r_sum[w_bit_pos +: 2] <= w_slice[1:0];
        r_carry <= w_slice[2];
        r_idx   <= r_idx + 1'b1;
        if (r_idx == c_last_idx) begin
          r_state   <= c_st_idle;
          r_cout    <= w_slice[2];
          r_done    <= 1'b1;
          r_done_id <= r_last;
        end
      end
    end
  end

  assign bus.gnt0    = r_gnt0;
  assign bus.gnt1    = r_gnt1;
  assign bus.busy    = (r_state == c_st_add);
  assign bus.done    = r_done;
  assign bus.done_id = r_done_id;
  assign bus.sum     = r_sum;
  assign bus.cout    = r_cout;
endmodule
`default_nettype wire

// File: tb/tb_serial_add_arbiter.sv
`default_nettype none
// ============================================================================
// tb_serial_add_arbiter : directed checks of arbitration and serial add
// Revision: 1.0
// ============================================================================
module tb_serial_add_arbiter;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   cyc;

  serial_add_arbiter_if #(.WIDTH(8)) bus ();

  serial_add_arbiter #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_reqs;
    bus.req0 = 1'b0; bus.a0 = 8'h00; bus.b0 = 8'h00; bus.cin0 = 1'b0;
    bus.req1 = 1'b0; bus.a1 = 8'h00; bus.b1 = 8'h00; bus.cin1 = 1'b0;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    clear_reqs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clear_reqs();
    bus.req0 = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.done_id} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got gnt0,gnt1,busy,done,id=%b required 00000",
               {bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.done_id});
    end
    n_cmp++;
    if ({bus.cout, bus.sum} !== 9'h000) begin
      n_err++;
      $display("FAIL reset_sum: got cout,sum=%h required 000", {bus.cout, bus.sum});
    end
    bus.req0 = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single(input string name, input bit who, input logic [7:0] a,
                             input logic [7:0] b, input bit cin, input logic [7:0] exp_sum,
                             input bit exp_cout);
    int nb;
    int early;
    nb = 0;
    early = 0;
    if (!who) begin
      bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; bus.cin0 = cin;
    end else begin
      bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b; bus.cin1 = cin;
    end
    tick();
    n_cmp++;
    if ({bus.gnt1, bus.gnt0} !== (who ? 2'b10 : 2'b01)) begin
      n_err++;
      $display("FAIL %s_gnt: got gnt1,gnt0=%b required %b", name, {bus.gnt1, bus.gnt0},
               who ? 2'b10 : 2'b01);
    end
    clear_reqs();
    if (bus.busy) nb++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.busy) nb++;
      if (bus.done || bus.gnt0 || bus.gnt1) early++;
    end
    n_cmp++;
    if (early !== 0) begin
      n_err++;
      $display("FAIL %s_early: got %0d stray done/gnt cycles required 0", name, early);
    end
    tick();
    n_cmp++;
    if (nb !== 4 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_busy: got %0d busy cycles (busy now %b) required 4 (0)", name, nb, bus.busy);
    end
    n_cmp++;
    if ({bus.done, bus.done_id, bus.cout, bus.sum} !== {1'b1, who, exp_cout, exp_sum}) begin
      n_err++;
      $display("FAIL %s_result: got done=%b id=%b cout=%b sum=%h required 1 %b %b %h", name,
               bus.done, bus.done_id, bus.cout, bus.sum, who, exp_cout, exp_sum);
    end
    tick();
    n_cmp++;
    if (bus.done !== 1'b0 || bus.sum !== exp_sum) begin
      n_err++;
      $display("FAIL %s_hold: got done=%b sum=%h required 0 %h", name, bus.done, bus.sum, exp_sum);
    end
  endtask

  task automatic test_fairness;
    int ng;
    int nd;
    bit g_seq[4];
    bit d_seq[4];
    logic [7:0] d_sum[4];
    int d_cyc[4];
    ng = 0;
    nd = 0;
    apply_reset();
    bus.req0 = 1'b1; bus.a0 = 8'h03; bus.b0 = 8'h04;
    bus.req1 = 1'b1; bus.a1 = 8'h10; bus.b1 = 8'h20;
    for (int c = 0; c < 40 && nd < 4; c++) begin
      tick();
      if ((bus.gnt0 || bus.gnt1) && ng < 4) begin
        g_seq[ng] = bus.gnt1;
        ng++;
      end
      if (bus.done) begin
        d_seq[nd] = bus.done_id;
        d_sum[nd] = bus.sum;
        d_cyc[nd] = cyc;
        nd++;
      end
    end
    clear_reqs();
    n_cmp++;
    if (ng !== 4 || nd !== 4) begin
      n_err++;
      $display("FAIL fair_count: got %0d grants %0d dones required 4 4", ng, nd);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < ng && i < nd) begin
        n_cmp++;
        if (g_seq[i] !== i[0] || d_seq[i] !== i[0] || d_sum[i] !== (i[0] ? 8'h30 : 8'h07)) begin
          n_err++;
          $display("FAIL fair_op%0d: got gnt_id=%b done_id=%b sum=%h required %b %b %h", i,
                   g_seq[i], d_seq[i], d_sum[i], i[0], i[0], i[0] ? 8'h30 : 8'h07);
        end
        if (i > 0) begin
          n_cmp++;
          if (d_cyc[i] - d_cyc[i-1] !== 5) begin
            n_err++;
            $display("FAIL fair_gap%0d: got %0d cycles required 5", i, d_cyc[i] - d_cyc[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_add;
    int nd;
    int waited;
    nd = 0;
    apply_reset();
    bus.req0 = 1'b1; bus.a0 = 8'h05; bus.b0 = 8'h0A;
    tick();
    clear_reqs();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if ({bus.busy, bus.done, bus.cout, bus.sum} !== 11'h000) begin
      n_err++;
      $display("FAIL abort_state: got busy=%b done=%b cout=%b sum=%h required 0 0 0 00",
               bus.busy, bus.done, bus.cout, bus.sum);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done) nd++;
    end
    n_cmp++;
    if (nd !== 0) begin
      n_err++;
      $display("FAIL abort_done: got %0d done pulses required 0", nd);
    end
    bus.req0 = 1'b1; bus.a0 = 8'h0F; bus.b0 = 8'h01;
    bus.req1 = 1'b1; bus.a1 = 8'h55; bus.b1 = 8'h11;
    tick();
    n_cmp++;
    if ({bus.gnt1, bus.gnt0} !== 2'b01) begin
      n_err++;
      $display("FAIL abort_tie: got gnt1,gnt0=%b required 01", {bus.gnt1, bus.gnt0});
    end
    clear_reqs();
    waited = 0;
    while (!bus.done && waited < 10) begin
      tick();
      waited++;
    end
    n_cmp++;
    if (bus.done !== 1'b1 || bus.sum !== 8'h10 || bus.done_id !== 1'b0) begin
      n_err++;
      $display("FAIL abort_next: got done=%b sum=%h id=%b required 1 10 0",
               bus.done, bus.sum, bus.done_id);
    end
  endtask

  task automatic test_back_to_back;
    int ng;
    int nd;
    int g_cyc[3];
    int d_cyc[3];
    ng = 0;
    nd = 0;
    apply_reset();
    bus.req0 = 1'b1; bus.a0 = 8'h01; bus.b0 = 8'h02;
    for (int c = 0; c < 30 && ng < 3; c++) begin
      tick();
      if (bus.gnt1) ng = 99;
      if (bus.gnt0 && ng < 3) begin
        g_cyc[ng] = cyc;
        ng++;
      end
      if (bus.done && nd < 3) begin
        d_cyc[nd] = cyc;
        nd++;
      end
    end
    clear_reqs();
    n_cmp++;
    if (ng !== 3 || nd < 2) begin
      n_err++;
      $display("FAIL b2b_count: got %0d grants %0d dones required 3 >=2", ng, nd);
    end
    for (int i = 1; i < 3; i++) begin
      if (ng == 3 && nd >= i) begin
        n_cmp++;
        if (g_cyc[i] - g_cyc[i-1] !== 5 || g_cyc[i] - d_cyc[i-1] !== 1) begin
          n_err++;
          $display("FAIL b2b_gap%0d: got gnt gap %0d, gnt-after-done %0d required 5 1", i,
                   g_cyc[i] - g_cyc[i-1], g_cyc[i] - d_cyc[i-1]);
        end
      end
    end
    for (int i = 0; i < 6; i++) tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    rst_n = 1'b0;
    clear_reqs();
    test_reset();
    test_single("add0", 1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
    test_single("add1", 1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    test_single("carry", 1'b0, 8'h7F, 8'h80, 1'b1, 8'h00, 1'b1);
    test_fairness();
    test_reset_mid_add();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
